// File: rtl/cpu_isa_pkg.sv
// ISA definitions for the 4-bit CPU: opcode map, fetch FSM states and
// instruction length decode.
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_OPERAND,
        S_DISPATCH,
        S_HALTED
    } state_e;

    // Reserved opcodes 0xB-0xE fall through as 1-byte instructions.
    function automatic logic is_two_byte(input logic [3:0] opcode);
        return opcode inside {OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JC};
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/dispatch sequencer: reads instruction bytes at the PC, hands one
// decoded instruction to execute, and steps the PC (hold, +1, +2 or jump).
module fetch_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_halt,
    output logic              pc_jump_enable,
    output logic [ADDR_W-1:0] pc_jump_addr,
    output logic              pc_inc_2,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              exec_busy,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic              resume,
    output logic              instr_valid,
    output logic [3:0]        instr_opcode,
    output logic [3:0]        instr_imm,
    output logic [DATA_W-1:0] instr_operand,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [3:0]          opcode;
    logic                take_jump;

    assign opcode        = ir_q[DATA_W-1 -: 4];
    assign instr_opcode  = opcode;
    assign instr_imm     = ir_q[3:0];
    assign instr_operand = operand_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        operand_d      = operand_q;
        pc_halt        = 1'b1;
        pc_jump_enable = 1'b0;
        pc_inc_2       = 1'b0;
        instr_valid    = 1'b0;
        halted         = 1'b0;
        rom_addr       = pc;
        take_jump      = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Operand is cleared here so 1-byte instructions present 0.
                ir_d      = rom_data;
                operand_d = '0;
                state_d   = is_two_byte(rom_data[DATA_W-1 -: 4]) ? S_OPERAND : S_DISPATCH;
            end
            S_OPERAND: begin
                rom_addr  = pc + ADDR_W'(1);
                operand_d = rom_data;
                state_d   = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (!exec_busy) begin
                    instr_valid = 1'b1;
                    if (opcode == OP_HLT) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_FETCH;
                        pc_halt = 1'b0;
                        case (opcode)
                            OP_JMP:  take_jump = 1'b1;
                            OP_JZ:   take_jump = zero_flag;
                            OP_JC:   take_jump = carry_flag;
                            default: take_jump = 1'b0;
                        endcase
                        if (take_jump) begin
                            pc_jump_enable = 1'b1;
                        end else if (is_two_byte(opcode)) begin
                            pc_inc_2 = 1'b1;
                        end
                    end
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    pc_halt = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_jump_addr = pc_jump_enable ? ADDR_W'(operand_q) : '0;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control end of the program counter interface. It drives the PC's halt, jump and increment-by-2 inputs.
- Reads opcode and operand bytes from the program ROM at the current PC and resolves jumps against the ALU flags.
- Hands one decoded instruction at a time to the execute stage.
- Sits between program_counter, program ROM and execute unit of the 4-bit CPU.

Parameters:
- ADDR_W, 8, PC / ROM address width; must equal the PC width.
- DATA_W, 8, ROM byte width; opcode = byte[7:4], immediate = byte[3:0].

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- pc  in  8  current PC value from program_counter
- pc_halt  out  1  to PC halt; 1 holds the PC
- pc_jump_enable  out  1  to PC jump_enable
- pc_jump_addr  out  8  to PC jump_addr
- pc_inc_2  out  1  to PC pc_inc_2
- rom_addr  out  8  ROM read address
- rom_data  in  8  ROM data; combinational, valid in the same cycle as rom_addr
- exec_busy  in  1  execute stage not ready for a new instruction
- zero_flag  in  1  ALU Z flag, valid while exec_busy=0
- carry_flag  in  1  ALU C flag, valid while exec_busy=0
- resume  in  1  leave HALTED state
- instr_valid  out  1  1-cycle pulse: instruction handed to execute
- instr_opcode  out  4  registered opcode
- instr_imm  out  4  registered low nibble of the opcode byte
- instr_operand  out  8  registered second byte; 0 for 1-byte instructions
- halted  out  1  1 while in HALTED

Behaviour:
Opcode map:
- 1-byte: 0x0 NOP, 0x1 LDI, 0x2 ADD, 0x3 SUB, 0x6 AND, 0x7 OR.
- 2-byte: 0x4 LDA, 0x5 STA, 0x8 JMP, 0x9 JZ, 0xA JC.
- 0xF HLT.
- 0xB-0xE reserved; decoded as 1-byte NOP (instr_valid still pulses, opcode passed through unchanged).

States:
- FETCH
  - rom_addr=pc; capture rom_data into IR.
  - 2-byte opcode -> OPERAND; otherwise -> DISPATCH.
- OPERAND
  - rom_addr=pc+1 (8-bit wrap: pc=0xFF reads 0x00); capture byte into operand register.
  - -> DISPATCH.
- DISPATCH
  - Wait while exec_busy=1; outputs stable, pc_halt=1.
  - When exec_busy=0, "advance cycle":
    - instr_valid=1.
    - pc_halt=0 and exactly one PC action:
      - JMP always: jump_enable=1, jump_addr=operand.
      - JZ with zero_flag=1, JC with carry_flag=1: jump_enable=1, jump_addr=operand.
      - Any other 2-byte instruction, or JZ/JC not taken: pc_inc_2=1.
      - 1-byte instruction: plain +1 (jump_enable=0, pc_inc_2=0).
    - -> FETCH.
  - HLT with exec_busy=0: instr_valid=1, pc_halt stays 1, -> HALTED.
- HALTED
  - pc_halt=1, halted=1.
  - resume=1: one cycle with pc_halt=0 (PC +1 past HLT), -> FETCH.

Output rules:
- pc_halt=1 in every cycle except the advance cycle. The PC therefore changes only on the edge ending the advance cycle.
- rom_addr in DISPATCH/HALTED = pc (don't-care to ROM).
- Flags are sampled only in the advance cycle.

Latency:
- 1-byte instruction: 2 cycles (FETCH, DISPATCH) with exec_busy=0.
- 2-byte instruction: 3 cycles.
- Each extra exec_busy cycle adds 1.

Reset:
- Asynchronous, any state.
- State=FETCH; IR, operand, instr_* cleared to 0.
- Outputs: pc_halt=1, pc_jump_enable=0, pc_jump_addr=0, pc_inc_2=0, instr_valid=0, halted=0, rom_addr=pc.
- Reset mid-OPERAND/DISPATCH discards the partial instruction; no instr_valid is produced.

Simultaneous events:
- resume in a non-HALTED state is ignored.
- A flag change during DISPATCH while exec_busy=1 is ignored.
- jump_enable and pc_inc_2 are never both 1.

Decomposition:
- Package cpu_isa_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - state encoding (S_FETCH, S_OPERAND, S_DISPATCH, S_HALTED);
  - function is_two_byte(opcode).
- No sub-module; the single-FSM block includes the branch resolve logic inline.

Test Plan:
- ROM[0]=0x13 (LDI 3), exec_busy=0 -> instr_valid at cycle 2 with opcode=1, imm=3, operand=0; pc 0->1, pc_inc_2 never asserted.
- ROM[4]=0x80, ROM[5]=0x20 (JMP 0x20) -> operand read at rom_addr=5; advance cycle has jump_enable=1, jump_addr=0x20; next FETCH rom_addr=0x20.
- JZ 0x40 at pc=0x10, zero_flag=0 -> pc_inc_2=1, pc becomes 0x12. Repeat with zero_flag=1 -> pc becomes 0x40.
- exec_busy=1 for 3 cycles in DISPATCH -> pc frozen, instr_valid low until the cycle exec_busy drops, then a single pulse.
- HLT at pc=0x07 -> instr_valid pulse, halted=1, pc stays 0x07 for 10 cycles. resume=1 -> pc=0x08, FETCH.
- 2-byte LDA at pc=0xFF -> operand read from rom_addr=0x00, pc wraps to 0x01. Separately, reset_n low mid-OPERAND -> instr_valid never pulses, all outputs at reset values.
